// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package sub_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = a - b, barrow set when a < b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic barrow
);
  assign diff   = a ^ b;
  assign barrow = ~a & b;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor slice per clock.
// Two half_subtractor cells plus an OR form the slice; a borrow FF chains slices.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             hd0, hb0, d, hb1, slice_br;
  logic             load, last;

  half_subtractor hs0 (.a(a_sr[0]), .b(b_sr[0]), .diff(hd0), .barrow(hb0));
  half_subtractor hs1 (.a(hd0),     .b(br),      .diff(d),   .barrow(hb1));
  assign slice_br = hb0 | hb1;

  // New result bit enters at the MSB; after WIDTH slices the LSB is in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nxt = d;
    end else begin : g_wn
      assign res_nxt = {d, res_sr[WIDTH-1:1]};
    end
  endgenerate

  assign load = start && (state == S_IDLE || state == S_DONE);
  assign last = (state == S_BUSY) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load) state_nxt = S_BUSY;
      S_BUSY:  if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = load ? S_BUSY : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_BUSY);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      a_sr <= a_in;
      b_sr <= b_in;
      br   <= borrow_in;
      cnt  <= '0;
    end else if (state == S_BUSY) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br     <= slice_br;
      res_sr <= res_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff_out   <= res_nxt;
        borrow_out <= slice_br;
      end
    end
  end
endmodule
